// File: rtl/seq_uart_arb_pkg.sv
// Shared definitions for the sequencer UART report arbiter.
//   SEQ_DP_WIDTH : default width of a reported data word
//   arb_state_t  : arbiter FSM states (legacy encodings kept: 0..3)
//   rr_next      : round-robin pointer advance, wraps at the requester count
package seq_uart_arb_pkg;

  localparam int unsigned SEQ_DP_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_t;

  // Next pointer after granting idx; always 0 when only one requester exists.
  function automatic logic [1:0] rr_next(input logic [1:0] idx, input int unsigned n);
    return ((32'(idx) + 32'd1) >= n) ? 2'd0 : (idx + 2'd1);
  endfunction

endpackage

// File: rtl/seq_rr_pick.sv
// Combinational round-robin picker.
//   i_pend  : pending vector, one bit per requester
//   i_ptr   : first index to consider; search ascends and wraps
//   o_grant : selected index (valid when o_any)
//   o_any   : at least one bit of i_pend is set
module seq_rr_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_pend,
  input  logic [1:0]         i_ptr,
  output logic [1:0]         o_grant,
  output logic               o_any
);

  always_comb begin
    o_grant = '0;
    o_any   = 1'b0;
    // Outer loop walks offsets from the pointer; inner loop maps the rotated
    // position back to a constant index so every select stays static.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!o_any && (j == ((32'(i_ptr) + i) % NUM_REQ)) && i_pend[j]) begin
          o_any   = 1'b1;
          o_grant = 2'(j);
        end
      end
    end
  end

endmodule

// File: rtl/seq_uart_arb.sv
// Round-robin arbiter sharing one UART hex reporter among NUM_REQ requesters.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_req        : per-requester request pulse
//   i_req_data   : packed request words, requester k at [k*DP_WIDTH +: DP_WIDTH]
//   o_req_ack    : request k accepted into its slot (1-cycle pulse)
//   o_pend       : slot k occupied
//   o_tx_data    : word to reporter (i_tx_data)
//   o_tx_reg     : granted requester index (i_reg)
//   o_tx_stb     : 1-cycle issue strobe (i_tx_stb)
//   i_tx_busy    : reporter busy (o_tx_busy)
//   o_busy       : arbiter not idle
//   o_drop_cnt   : saturating count of rejected requests
module seq_uart_arb
  import seq_uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DP_WIDTH = SEQ_DP_WIDTH,
  parameter int unsigned DROP_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           i_req,
  input  logic [NUM_REQ*DP_WIDTH-1:0]  i_req_data,
  output logic [NUM_REQ-1:0]           o_req_ack,
  output logic [NUM_REQ-1:0]           o_pend,
  output logic [DP_WIDTH-1:0]          o_tx_data,
  output logic [1:0]                   o_tx_reg,
  output logic                         o_tx_stb,
  input  logic                         i_tx_busy,
  output logic                         o_busy,
  output logic [DROP_W-1:0]            o_drop_cnt
);

  arb_state_t            r_state;
  logic [NUM_REQ-1:0]    r_pend;
  logic [NUM_REQ-1:0]    r_ack;
  logic [DP_WIDTH-1:0]   r_slot [NUM_REQ];
  logic [1:0]            r_ptr;
  logic [DP_WIDTH-1:0]   r_tx_data;
  logic [1:0]            r_tx_reg;
  logic [DROP_W-1:0]     r_drop;

  logic [1:0]            w_grant;
  logic                  w_any;
  logic                  w_fire;
  logic [NUM_REQ-1:0]    w_gnt_vec;
  logic [NUM_REQ-1:0]    w_accept;
  logic [NUM_REQ-1:0]    w_drop;
  logic [DP_WIDTH-1:0]   w_gnt_data;
  logic [DROP_W:0]       w_drop_sum;
  logic [DROP_W-1:0]     w_drop_next;

  seq_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_pend  (r_pend),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_any   (w_any)
  );

  always_comb begin
    w_fire     = (r_state == ST_IDLE) && w_any && !i_tx_busy;
    w_gnt_vec  = '0;
    w_accept   = '0;
    w_drop     = '0;
    w_gnt_data = '0;
    w_drop_sum = {1'b0, r_drop};
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_gnt_vec[k] = w_fire && (w_grant == 2'(k));
      // A slot being emptied by this cycle's grant can take a new word at once.
      w_accept[k]  = i_req[k] && (!r_pend[k] || w_gnt_vec[k]);
      w_drop[k]    = i_req[k] && r_pend[k] && !w_gnt_vec[k];
      if (w_grant == 2'(k)) w_gnt_data = r_slot[k];
      if (w_drop[k]) w_drop_sum = w_drop_sum + {{DROP_W{1'b0}}, 1'b1};
    end
    // One spare bit catches the carry from up to NUM_REQ simultaneous drops.
    w_drop_next = w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
  end

  // Slot data needs no reset: it is only read while its pending bit is set.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (w_accept[k]) r_slot[k] <= i_req_data[k*DP_WIDTH +: DP_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_pend    <= '0;
      r_ack     <= '0;
      r_ptr     <= '0;
      r_tx_data <= '0;
      r_tx_reg  <= '0;
      r_drop    <= '0;
    end else begin
      r_ack  <= w_accept;
      r_drop <= w_drop_next;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (w_accept[k])       r_pend[k] <= 1'b1;
        else if (w_gnt_vec[k]) r_pend[k] <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_fire) begin
            r_tx_data <= w_gnt_data;
            r_tx_reg  <= w_grant;
            r_ptr     <= rr_next(w_grant, NUM_REQ);
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE:     r_state <= ST_WAIT_BUSY;
        ST_WAIT_BUSY: if (i_tx_busy)  r_state <= ST_WAIT_DONE;
        ST_WAIT_DONE: if (!i_tx_busy) r_state <= ST_IDLE;
        default:      r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_req_ack  = r_ack;
  assign o_pend     = r_pend;
  assign o_tx_data  = r_tx_data;
  assign o_tx_reg   = r_tx_reg;
  assign o_tx_stb   = (r_state == ST_ISSUE);
  assign o_busy     = (r_state != ST_IDLE);
  assign o_drop_cnt = r_drop;

endmodule

// File: tb/tb_seq_uart_arb.sv
// Bench for seq_uart_arb: directed stimulus pushes expected {reg,data} issues
// into a queue; a monitor pops and compares on every o_tx_stb. A simple
// reporter model raises busy the cycle after a strobe for line_len cycles.
module tb_seq_uart_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  i_req = '0;
  logic [63:0] i_req_data = '0;
  logic [3:0]  o_req_ack, o_pend;
  logic [15:0] o_tx_data;
  logic [1:0]  o_tx_reg;
  logic        o_tx_stb, o_busy;
  logic [7:0]  o_drop_cnt;
  logic        busy_m = 1'b0;

  int unsigned line_len = 20;
  int unsigned cnt_m = 0;
  int unsigned cyc = 0;
  int unsigned fall_cyc = 0;
  int unsigned stb_cnt = 0;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  logic [17:0] exp_q [$];

  always #5 clk = ~clk;

  seq_uart_arb #(.NUM_REQ(4), .DP_WIDTH(16), .DROP_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (i_req),
    .i_req_data (i_req_data),
    .o_req_ack  (o_req_ack),
    .o_pend     (o_pend),
    .o_tx_data  (o_tx_data),
    .o_tx_reg   (o_tx_reg),
    .o_tx_stb   (o_tx_stb),
    .i_tx_busy  (busy_m),
    .o_busy     (o_busy),
    .o_drop_cnt (o_drop_cnt)
  );

  // Reporter model: not reset by the arbiter's reset.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_tx_stb) begin
      busy_m <= 1'b1;
      cnt_m  <= line_len;
    end else if (cnt_m != 0) begin
      cnt_m <= cnt_m - 1;
      if (cnt_m == 1) begin
        busy_m   <= 1'b0;
        fall_cyc <= cyc + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every issued strobe must match the next expected issue.
  always @(negedge clk) begin
    if (rst_n && o_tx_stb) begin
      stb_cnt++;
      if (exp_q.size() == 0) chk("unexpected_stb", {14'd0, o_tx_reg, o_tx_data}, 32'h3FFFF);
      else chk("issue", {14'd0, o_tx_reg, o_tx_data}, {14'd0, exp_q.pop_front()});
    end
  end

  task automatic set_data(input int k, input logic [15:0] v);
    i_req_data[k*16 +: 16] = v;
  endtask

  // Pulse a request mask for one cycle, then check the ack pulse.
  task automatic req(input string name, input logic [3:0] m);
    @(negedge clk);
    i_req = m;
    @(negedge clk);
    i_req = '0;
    chk(name, {28'd0, o_req_ack}, {28'd0, m});
  endtask

  task automatic drain(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !o_busy && !busy_m && o_pend == 4'd0) done = 1'b1;
    end
    chk(name, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int unsigned s0;
    logic done;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_stb",  {31'd0, o_tx_stb}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_out",  {6'd0, o_tx_reg, o_tx_data, o_req_ack, o_pend}, 32'd0);
    chk("rst_drop", {24'd0, o_drop_cnt}, 32'd0);
    rst_n = 1'b1;

    // All four in the same cycle, rr pointer 0
    line_len = 20;
    set_data(0, 16'h1111); set_data(1, 16'h2222); set_data(2, 16'h3333); set_data(3, 16'h4444);
    exp_q.push_back({2'd0, 16'h1111}); exp_q.push_back({2'd1, 16'h2222});
    exp_q.push_back({2'd2, 16'h3333}); exp_q.push_back({2'd3, 16'h4444});
    s0 = stb_cnt;
    req("all4_ack", 4'b1111);
    drain("all4_drain");
    chk("all4_stb_count", stb_cnt - s0, 32'd4);
    chk("all4_no_drop", {24'd0, o_drop_cnt}, 32'd0);

    // Single request, latency and busy fall
    line_len = 60;
    set_data(2, 16'hBEEF);
    exp_q.push_back({2'd2, 16'hBEEF});
    req("single_ack", 4'b0100);
    chk("single_pend", {28'd0, o_pend}, 32'h4);
    @(negedge clk);
    chk("single_stb_lat", {31'd0, o_tx_stb}, 32'd1);
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!o_busy) done = 1'b1;
    end
    chk("single_idle", {31'd0, done}, 32'd1);
    chk("single_busy_fall", cyc, fall_cyc + 1);
    chk("single_hold", {14'd0, o_tx_reg, o_tx_data}, {14'd0, 2'd2, 16'hBEEF});

    // Fairness: grant 1 first, then 0 and 3 pending -> 3 then 0
    line_len = 20;
    set_data(1, 16'h0A01); set_data(0, 16'h0A00); set_data(3, 16'h0A03);
    exp_q.push_back({2'd1, 16'h0A01});
    exp_q.push_back({2'd3, 16'h0A03});
    exp_q.push_back({2'd0, 16'h0A00});
    req("rr_ack1", 4'b0010);
    req("rr_ack03", 4'b1001);
    drain("rr_drain");

    // Overflow: slot 0 full for 300 request pulses
    line_len = 400;
    set_data(1, 16'h7777); set_data(0, 16'hA5A5);
    exp_q.push_back({2'd1, 16'h7777});
    exp_q.push_back({2'd0, 16'hA5A5});
    req("ovf_ack1", 4'b0010);
    req("ovf_ack0", 4'b0001);
    @(negedge clk);
    set_data(0, 16'hDEAD);
    i_req = 4'b0001;
    for (int p = 1; p <= 300; p++) begin
      @(negedge clk);
      if (p == 100) chk("ovf_drop100", {24'd0, o_drop_cnt}, 32'd100);
      if (p == 255) chk("ovf_drop255", {24'd0, o_drop_cnt}, 32'd255);
      if (p == 300) chk("ovf_drop_sat", {24'd0, o_drop_cnt}, 32'd255);
    end
    i_req = '0;
    chk("ovf_no_ack", {28'd0, o_req_ack}, 32'd0);
    drain("ovf_drain");

    // Same-cycle refill of the slot being granted
    line_len = 20;
    exp_q.push_back({2'd1, 16'h1A1A});
    exp_q.push_back({2'd1, 16'h1B1B});
    @(negedge clk);
    set_data(1, 16'h1A1A);
    i_req = 4'b0010;
    @(negedge clk);
    chk("refill_ack1", {28'd0, o_req_ack}, 32'h2);
    set_data(1, 16'h1B1B);
    @(negedge clk);
    i_req = '0;
    chk("refill_ack2", {28'd0, o_req_ack}, 32'h2);
    chk("refill_pend", {28'd0, o_pend}, 32'h2);
    chk("refill_no_drop", {24'd0, o_drop_cnt}, 32'd255);
    drain("refill_drain");

    // Asynchronous reset in WAIT_DONE
    line_len = 100;
    set_data(2, 16'hC0DE);
    exp_q.push_back({2'd2, 16'hC0DE});
    req("wd_ack", 4'b0100);
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (busy_m) done = 1'b1;
    end
    chk("wd_busy_seen", {31'd0, done}, 32'd1);
    repeat (5) @(negedge clk);
    chk("wd_busy_before", {31'd0, o_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, o_busy}, 32'd0);
    chk("arst_out", {6'd0, o_tx_reg, o_tx_data, o_req_ack, o_pend}, 32'd0);
    chk("arst_drop", {24'd0, o_drop_cnt}, 32'd0);
    chk("arst_stb", {31'd0, o_tx_stb}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    s0 = stb_cnt;
    repeat (5) @(negedge clk);
    set_data(3, 16'h3333);
    exp_q.push_back({2'd3, 16'h3333});
    req("post_rst_ack", 4'b1000);
    for (int i = 0; i < 200 && busy_m; i++) @(negedge clk);
    chk("no_stb_while_busy", stb_cnt - s0, 32'd0);
    drain("post_rst_drain");
    chk("post_rst_stb_count", stb_cnt - s0, 32'd1);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
